// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between NUM_REQ valid/ready requesters with locked multi-byte messages.
// Ports: i_clk/i_rst clock and sync active-high reset; i_req_valid/i_req_data/i_req_last/o_req_ready per-requester handshake;
// o_TX_Data/o_TX_DataValid/i_busy UART transmitter side; o_grant/o_grant_idx current (or last) owner; o_timeout abort pulse.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT  = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_TX_Data,
  output logic                 o_TX_DataValid,
  input  logic                 i_busy,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [2:0]           o_grant_idx,
  output logic                 o_timeout
);
  localparam int TMAX = START_TIMEOUT > LOCK_TIMEOUT ? START_TIMEOUT : LOCK_TIMEOUT;
  localparam int CW = $clog2(TMAX);
  typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;
  state_t state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, sel_oh;
  logic [2:0] idx_q, idx_d, sel, nxt;
  logic lock_q, lock_d, to_q, to_d, found;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] valid8, last8;
  logic [63:0] data64;
  logic [3:0] sum;
  assign valid8 = 8'(i_req_valid);
  assign last8 = 8'(i_req_last);
  assign data64 = 64'(i_req_data);
  // rotating priority: first valid requester after the most recent owner
  always_comb begin
    sel = idx_q;
    found = 1'b0;
    sum = '0;
    nxt = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, idx_q} + 4'(k);
      nxt = 3'(sum >= 4'(NUM_REQ) ? sum - 4'(NUM_REQ) : sum);
      if (!found && valid8[nxt]) begin
        found = 1'b1;
        sel = nxt;
      end
    end
  end
  assign sel_oh = NUM_REQ'(8'd1 << sel);
  assign o_req_ready = i_rst ? '0 :
                       (state_q == IDLE && found) ? sel_oh :
                       (state_q == HOLD) ? (i_req_valid & grant_q) : '0;
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    grant_d = grant_q;
    idx_d = idx_q;
    lock_d = lock_q;
    to_d = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        state_d = SEND;
        data_d = data64[{sel, 3'b000} +: 8];
        idx_d = sel;
        grant_d = sel_oh;
        lock_d = ~last8[sel];
      end
      SEND: if (i_busy) begin
        state_d = WAIT;
      end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
        state_d = IDLE;
        to_d = 1'b1;
        lock_d = 1'b0;
        grant_d = '0;
      end
      WAIT: if (!i_busy) begin
        state_d = lock_q ? HOLD : IDLE;
        grant_d = lock_q ? grant_q : '0;
      end
      HOLD: if (valid8[idx_q]) begin
        state_d = SEND;
        data_d = data64[{idx_q, 3'b000} +: 8];
        lock_d = ~last8[idx_q];
      end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
        state_d = IDLE;
        to_d = 1'b1;
        lock_d = 1'b0;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      data_q <= '0;
      grant_q <= '0;
      idx_q <= 3'(NUM_REQ - 1);
      lock_q <= 1'b0;
      to_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      grant_q <= grant_d;
      idx_q <= idx_d;
      lock_q <= lock_d;
      to_q <= to_d;
      cnt_q <= cnt_d;
    end
  end
  assign o_TX_Data = data_q;
  assign o_TX_DataValid = (state_q == SEND);
  assign o_grant = grant_q;
  assign o_grant_idx = idx_q;
  assign o_timeout = to_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed checks of uart_tx_arbiter against a message-level reference model.
module tb_uart_tx_arbiter;
  localparam int N = 4, ST = 64, LT = 1024;
  logic clk = 1'b0, rst = 1'b1, busy = 1'b0;
  logic [N-1:0] valid = '0, last = '0, ready, grant, acc = '0;
  logic [8*N-1:0] data = '0;
  logic [7:0] tx;
  logic dv, to;
  logic [2:0] gidx;
  int n_chk = 0, n_fail = 0;
  int m_owner = -1, m_last = N - 1, m_send = -1, m_hold = -1;
  logic m_wait = 0, m_locked = 0, m_to = 0;
  logic [7:0] m_tx = 0;
  int dl = 0, bl = 0, bdel = 2, blen = 20;
  logic busy_en = 1, rnd = 0, prev_dv = 0;
  logic [N-1:0] s_ready, s_grant;
  logic [7:0] s_data;
  logic s_dv, s_to, s_busy;
  int log_idx[$];
  logic [7:0] log_data[$];
  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(ST), .LOCK_TIMEOUT(LT)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_data(data), .i_req_last(last),
    .o_req_ready(ready), .o_TX_Data(tx), .o_TX_DataValid(dv), .i_busy(busy),
    .o_grant(grant), .o_grant_idx(gidx), .o_timeout(to));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [N-1:0] m_ready();
    if (rst) return '0;
    if (m_owner < 0) begin
      for (int j = 1; j <= N; j++) if (valid[(m_last + j) % N]) return N'(1) << ((m_last + j) % N);
      return '0;
    end
    if (m_hold >= 0) return valid & (N'(1) << m_owner);
    return '0;
  endfunction
  task automatic abort_msg();
    m_owner = -1;
    m_locked = 0;
    m_send = -1;
    m_hold = -1;
    m_wait = 0;
    m_to = 1;
  endtask
  task automatic step();
    logic [N-1:0] r;
    if (bl > 0) begin
      busy = 1;
      bl--;
    end else if (dl > 0) begin
      dl--;
      busy = (dl == 0);
      if (dl == 0) bl = blen - 1;
    end else begin
      busy = 0;
      if (dv && busy_en) begin
        if (rnd) begin
          bdel = $urandom_range(1, 3);
          blen = $urandom_range(1, 6);
          if ($urandom_range(0, 19) == 0) bdel = 70;
        end
        dl = bdel;
      end
    end
    #2;
    r = m_ready();
    chk("ready", 32'(ready), 32'(r));
    chk("tx_valid", 32'(dv), 32'(m_send >= 0));
    chk("tx_data", 32'(tx), 32'(m_tx));
    chk("grant", 32'(grant), 32'(m_owner < 0 ? N'(0) : N'(1) << m_owner));
    chk("grant_idx", 32'(gidx), 32'(m_last));
    chk("timeout", 32'(to), 32'(m_to));
    s_ready = ready; s_grant = grant; s_data = tx; s_dv = dv; s_to = to; s_busy = busy;
    if (dv && !prev_dv) begin
      log_idx.push_back(int'(gidx));
      log_data.push_back(tx);
    end
    prev_dv = dv;
    acc = r & valid;
    m_to = 0;
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_locked = 0; m_send = -1; m_wait = 0; m_hold = -1; m_tx = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) if (r[k]) begin
        m_owner = k; m_last = k; m_tx = data[8*k +: 8]; m_locked = !last[k]; m_send = 0;
      end
    end else if (m_send >= 0) begin
      if (busy) begin
        m_send = -1; m_wait = 1;
      end else if (m_send + 1 == ST) abort_msg();
      else m_send++;
    end else if (m_wait) begin
      if (!busy) begin
        m_wait = 0;
        if (m_locked) m_hold = 0;
        else m_owner = -1;
      end
    end else begin
      if (valid[m_owner]) begin
        m_tx = data[8*m_owner +: 8]; m_locked = !last[m_owner]; m_hold = -1; m_send = 0;
      end else if (m_hold + 1 == LT) abort_msg();
      else m_hold++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; valid = '0; dl = 0; bl = 0; busy_en = 1;
    step();
    step();
    rst = 0;
    log_idx.delete();
    log_data.delete();
  endtask
  task automatic wait_idle(input int bound);
    logic ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      step();
      ok = (m_owner < 0 && dl == 0 && bl == 0);
    end
    chk("idle_wait", 32'(ok), 32'(1));
  endtask
  task automatic wait_log(input int n, input int bound);
    for (int i = 0; i < bound && log_idx.size() < n; i++) step();
    chk("log_wait", 32'(log_idx.size()), 32'(n));
  endtask
  initial begin
    int hc, dvc, toc;
    logic got;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_grant_idx", 32'(gidx), 32'(3));
    chk("rst_grant", 32'(grant), 32'(0));
    bdel = 2; blen = 20;
    valid = 4'b0010; last = 4'b1111; data = '0; data[15:8] = 8'h41;
    step();
    chk("single_ready", 32'(s_ready), 32'(4'b0010));
    valid = '0;
    step();
    chk("single_dv", 32'(s_dv), 32'(1));
    chk("single_data", 32'(s_data), 32'(8'h41));
    wait_idle(100);
    step();
    chk("single_release", 32'(s_grant), 32'(0));
    do_reset();
    bdel = 1; blen = 3;
    valid = 4'b1111; last = 4'b1111; data = {8'h13, 8'h12, 8'h11, 8'h10};
    wait_log(5, 400);
    valid = '0;
    for (int i = 0; i < 5 && i < log_idx.size(); i++) begin
      chk("rr_order", 32'(log_idx[i]), 32'(i % 4));
      chk("rr_data", 32'(log_data[i]), 32'(8'h10 + i % 4));
    end
    wait_idle(100);
    do_reset();
    bdel = 2; blen = 4;
    valid = 4'b0100; last = 4'b1011; data = '0; data[23:16] = "H";
    step();
    chk("lock_first_ready", 32'(s_ready), 32'(4'b0100));
    data[23:16] = "I"; last[2] = 1; data[7:0] = "A"; valid = 4'b0101;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      got = acc[2];
    end
    chk("lock_second_accept", 32'(got), 32'(1));
    valid[2] = 0;
    wait_log(3, 300);
    valid = '0;
    if (log_idx.size() >= 3) begin
      chk("lock_order0", 32'(log_idx[0]), 32'(2));
      chk("lock_order1", 32'(log_idx[1]), 32'(2));
      chk("lock_order2", 32'(log_idx[2]), 32'(0));
      chk("lock_byte_I", 32'(log_data[1]), 32'(8'h49));
    end
    wait_idle(100);
    do_reset();
    busy_en = 0;
    valid = 4'b0001; last = 4'b1111; data[7:0] = 8'h55;
    step();
    valid = '0;
    dvc = 0; toc = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      dvc += int'(s_dv);
      toc += int'(s_to);
    end
    chk("st_dv_cycles", 32'(dvc), 32'(64));
    chk("st_pulses", 32'(toc), 32'(1));
    chk("st_grant", 32'(s_grant), 32'(0));
    do_reset();
    bdel = 1; blen = 2;
    valid = 4'b0010; last = 4'b1101; data[15:8] = 8'h77;
    step();
    valid = 4'b0001; last = 4'b1111;
    hc = 0;
    got = 0;
    for (int i = 0; i < 1200 && !got; i++) begin
      step();
      if (s_grant == 4'b0010 && !s_dv && !s_busy) hc++;
      got = s_to;
    end
    chk("lt_hold_cycles", 32'(hc), 32'(LT + 1));
    chk("lt_ready0", 32'(s_ready), 32'(4'b0001));
    valid = '0;
    wait_idle(100);
    do_reset();
    busy_en = 0;
    valid = 4'b0001;
    step();
    valid = '0;
    step();
    step();
    rst = 1; valid = 4'b1111;
    step();
    chk("rs_send_ready", 32'(s_ready), 32'(0));
    step();
    chk("rs_send_dv", 32'(s_dv), 32'(0));
    chk("rs_send_grant", 32'(s_grant), 32'(0));
    rst = 0; busy_en = 1; bdel = 1; blen = 2;
    step();
    chk("rs_send_first", 32'(s_ready), 32'(4'b0001));
    valid = '0;
    wait_idle(100);
    do_reset();
    bdel = 1; blen = 2;
    valid = 4'b0010; last = 4'b1101;
    step();
    valid = '0;
    for (int i = 0; i < 8; i++) step();
    chk("rs_hold_owner", 32'(s_grant), 32'(4'b0010));
    rst = 1; valid = 4'b1111;
    step();
    step();
    chk("rs_hold_dv", 32'(s_dv), 32'(0));
    chk("rs_hold_grant", 32'(s_grant), 32'(0));
    chk("rs_hold_ready", 32'(s_ready), 32'(0));
    rst = 0;
    step();
    chk("rs_hold_first", 32'(s_ready), 32'(4'b0001));
    valid = '0;
    wait_idle(100);
    rnd = 1; busy_en = 1;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      for (int k = 0; k < N; k++) begin
        if (acc[k] || !valid[k]) begin
          valid[k] = ($urandom_range(0, 2) == 0);
          data[8*k +: 8] = 8'($urandom);
          last[k] = 1'($urandom_range(0, 1));
        end else if ($urandom_range(0, 31) == 0) valid[k] = 0;
      end
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter (byte + DataValid in, busy out) between NUM_REQ requesters using per-requester valid/ready handshakes. It supports locked multi-byte messages: a requester keeps the grant until it sends a byte flagged last. It sits between application blocks (echo path, LED status reporter, etc.) and the uart instance, and replaces ad-hoc send/wait state machines in each application block.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
START_TIMEOUT, 64, cycles SEND waits for i_busy to rise before aborting (>=2).
LOCK_TIMEOUT, 1024, cycles HOLD waits for the next byte of a locked message before releasing (>=2).

Ports:
i_clk  in  1  system clock.
i_rst  in  1  synchronous reset, active-high.
i_req_valid  in  NUM_REQ  requester k has a byte on its data slice.
i_req_data  in  8*NUM_REQ  byte of requester k on bits [8k+7:8k].
i_req_last  in  NUM_REQ  byte of requester k ends its message; 0 requests lock.
o_req_ready  out  NUM_REQ  byte of requester k is accepted this cycle when valid&ready.
o_TX_Data  out  8  byte to UART transmitter.
o_TX_DataValid  out  1  send request to UART transmitter.
i_busy  in  1  UART transmitter busy.
o_grant  out  NUM_REQ  one-hot current owner; all zero when no owner.
o_grant_idx  out  3  index of current or most recent owner.
o_timeout  out  1  one-cycle pulse on any abort.

Behaviour:
- Reset (i_rst sampled high at posedge, any state): state=IDLE, o_TX_DataValid=0, o_TX_Data=0, o_grant=0, o_grant_idx=NUM_REQ-1 (so requester 0 has first priority), o_timeout=0, lock cleared, counters=0. o_req_ready=0 while i_rst is high.
- States: IDLE, SEND, WAIT, HOLD.
- IDLE: sel = first k with i_req_valid[k]=1, searching from (o_grant_idx+1) mod NUM_REQ upward with wrap. o_req_ready[sel]=1 combinationally, same cycle; all other ready bits are 0. On the edge: latch o_TX_Data=data[sel], o_grant_idx=sel, o_grant=onehot(sel), lock=~i_req_last[sel], and go to SEND. No valid: stay in IDLE, o_grant=0.
- SEND: o_TX_DataValid=1 and held. If i_busy=1, go to WAIT with o_TX_DataValid=0 next cycle. The counter increments each SEND cycle. Reaching START_TIMEOUT without busy: o_TX_DataValid=0, o_timeout pulse, lock cleared, o_grant=0, go to IDLE.
- WAIT: o_TX_DataValid=0. While i_busy=1, stay. On i_busy=0: if lock, go to HOLD; else o_grant=0 and go to IDLE.
- HOLD: only the owner is eligible. o_req_ready[owner]=i_req_valid[owner]. On a transfer: latch data, lock=~i_req_last[owner], go to SEND. Other requesters wait regardless of their valid. After LOCK_TIMEOUT cycles without a transfer: o_timeout pulse, lock cleared, o_grant=0, go to IDLE.
- Latency: a transfer in cycle N gives o_TX_DataValid=1 in cycle N+1. Minimum of 1 IDLE cycle between unlocked bytes. A locked byte can transfer in the first HOLD cycle.
- Handshake: a requester keeps valid, data and last stable until it sees ready. Dropping valid before acceptance is legal; the arbiter then picks another requester.
- Fairness: o_grant_idx updates only on IDLE grants. A locked message counts as one grant.
- Timeouts and reset never emit a partial o_TX_DataValid glitch. Reset mid-SEND drops o_TX_DataValid on the next cycle.
- Counters reset on every state entry.

Test Plan:
- Single request: req1 valid with data 0x41, last=1, in IDLE -> ready[1] high same cycle, o_TX_Data=0x41 with DataValid next cycle. Busy model (rises 2 cycles later, 20 cycles high) -> WAIT, then IDLE with o_grant=0.
- Round-robin: all 4 valid continuously, unlocked, after reset -> grant order 0,1,2,3,0; each o_TX_Data matches the owner's byte.
- Lock: req2 sends "H","I" with last=0,1 while req0 is valid throughout -> req0 is not granted until after "I" completes. Next IDLE grant goes to req3 if valid, else req0.
- Start timeout: i_busy held 0 -> DataValid held exactly 64 cycles, o_timeout single pulse, o_grant=0, IDLE.
- Lock timeout: req1 sends a last=0 byte then drops valid -> after 1024 HOLD cycles, o_timeout pulse, req0 is then granted.
- Reset mid-operation: assert i_rst during SEND and during HOLD -> next cycle o_TX_DataValid=0, o_grant=0, no ready. The first grant after release goes to req0.
